req_encoder: RTL

Sequential 8-to-3 request encoder for the ULA datapath, the inverse of the 3-to-8 one-hot decoder. It collects single-cycle request strobes on eight lines into a pending set. It serves them one at a time in round-robin order, presenting each as a 3-bit code under a valid/ready handshake. Control logic uses it to turn scattered event strobes back into operation/register indices.

---
 rtl/req_encoder_pkg.sv | 13 +
 rtl/req_encoder_rr_select.sv | 40 ++++
 rtl/req_encoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/req_encoder_pkg.sv
// Shared ULA definitions for the request encoder: request-line count,
// code width and the handshake FSM state type.
package req_encoder_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned W_REQ = $clog2(N_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage : req_encoder_pkg

// File: rtl/req_encoder_rr_select.sv
// Combinational round-robin picker over a pending set.
// Ports:
//   pend_i       - pending request set, one bit per line
//   ptr_i        - index searched first; search wraps modulo N
//   any_o        - at least one bit of pend_i is set
//   grant_o      - first set index at or after ptr_i (0 when none)
//   grant_mask_o - one-hot of grant_o, all zero when none
module req_encoder_rr_select
   import req_encoder_pkg::*;
#(
   parameter int unsigned N = N_REQ
) (
   input  logic [N-1:0]         pend_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic                 any_o,
   output logic [$clog2(N)-1:0] grant_o,
   output logic [N-1:0]         grant_mask_o
);

   localparam int unsigned W = $clog2(N);

   logic [W-1:0] idx;

   // N is a power of two, so W-bit addition wraps the search modulo N.
   always_comb begin
      any_o   = 1'b0;
      grant_o = '0;
      idx     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = ptr_i + W'(i);
         if (!any_o && pend_i[idx]) begin
            any_o   = 1'b1;
            grant_o = idx;
         end
      end
   end

   assign grant_mask_o = any_o ? (N'(1) << grant_o) : '0;

endmodule : req_encoder_rr_select

// File: rtl/req_encoder.sv
// Sequential N-to-log2(N) request encoder. Single-cycle strobes are merged
// into a pending set and served one at a time in round-robin order as a
// code under a valid/ready handshake.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   E     - capture enable; S ignored when low
//   S     - request strobes, one per line
//   A     - code of the request being presented
//   valid - A holds a request
//   ready - consumer accepts A when valid is high
//   pend  - pending set, excluding the request on A
//   dup   - one-cycle pulse: strobe hit a line already pending
module req_encoder
   import req_encoder_pkg::*;
#(
   parameter int unsigned N = N_REQ
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 E,
   input  logic [N-1:0]         S,
   output logic [$clog2(N)-1:0] A,
   output logic                 valid,
   input  logic                 ready,
   output logic [N-1:0]         pend,
   output logic                 dup
);

   localparam int unsigned W = $clog2(N);

   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic          valid_q, valid_d;
   logic [N-1:0]  pend_q, pend_d;
   logic          dup_q, dup_d;
   logic [W-1:0]  ptr_q, ptr_d;

   logic          any_c;
   logic [W-1:0]  grant_c;
   logic [N-1:0]  grant_mask_c;
   logic [N-1:0]  new_c;
   logic [N-1:0]  clr_c;

   // Selection sees only the registered pending set, never same-cycle strobes.
   req_encoder_rr_select #(
      .N (N)
   ) u_rr_select (
      .pend_i       (pend_q),
      .ptr_i        (ptr_q),
      .any_o        (any_c),
      .grant_o      (grant_c),
      .grant_mask_o (grant_mask_c)
   );

   assign new_c = E ? S : '0;

   // Next-state, output and pending-set logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      clr_c   = '0;

      unique case (state_q)
         IDLE: begin
            if (any_c) begin
               a_d     = grant_c;
               valid_d = 1'b1;
               clr_c   = grant_mask_c;
               ptr_d   = grant_c + W'(1);
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (ready) begin
               if (any_c) begin
                  a_d   = grant_c;
                  clr_c = grant_mask_c;
                  ptr_d = grant_c + W'(1);
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A new strobe wins over a grant clear on the same line.
      pend_d = (pend_q & ~clr_c) | new_c;
      dup_d  = |(new_c & pend_q);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         valid_q <= 1'b0;
         pend_q  <= '0;
         dup_q   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         valid_q <= valid_d;
         pend_q  <= pend_d;
         dup_q   <= dup_d;
         ptr_q   <= ptr_d;
      end
   end

   assign A     = a_q;
   assign valid = valid_q;
   assign pend  = pend_q;
   assign dup   = dup_q;

endmodule : req_encoder
